hilo_ctrl: RTL
==============

HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy length in cycles of MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy length in cycles of DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Req  input  1  exception/interrupt flush request from CP0.
REQ-006 SHALL have port start  input  1  E-stage instruction issues a HI/LO operation this cycle.
REQ-007 SHALL have port op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved/NONE.
REQ-008 SHALL have port A  input  32  rs operand.
REQ-009 SHALL have port B  input  32  rt operand.
REQ-010 SHALL have port rd_sel  input  1  0 selects LO, 1 selects HI onto HILO_out.
REQ-011 SHALL have port busy  output  1  registered; high while a multiply/divide is in flight.
REQ-012 SHALL have port stall  output  1  combinational pipeline stall request to the D-stage HI/LO hazard logic.
REQ-013 SHALL have port HI  output  32  architectural HI register.
REQ-014 SHALL have port LO  output  32  architectural LO register.
REQ-015 SHALL have port HILO_out  output  32  combinational HI or LO per rd_sel, feeding the E/M/W pipeline registers.

Function
REQ-016 SHALL implement states IDLE and BUSY with a down-counter cnt sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-017 SHALL define accept = start & ~Req & ~busy & ~reset; the op is captured only on a rising edge with accept high.
REQ-018 SHALL, on accept with op 1-4 in IDLE, latch A and B, move to BUSY, and load cnt = N-1, where N = MULT_CYCLES or DIV_CYCLES.
REQ-019 SHALL hold busy high for exactly N cycles following the accept edge, then return to IDLE.
REQ-020 SHALL write HI/LO on the edge that ends BUSY, making the new values visible on the first cycle in which busy is low.
REQ-021 SHALL produce MULT as a signed 64-bit product and MULTU as an unsigned one, with HI = bits 63:32 and LO = bits 31:0.
REQ-022 SHALL produce DIV results with LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend; DIVU SHALL use unsigned division.
REQ-023 SHALL leave HI and LO unchanged when a DIV/DIVU completes with latched B == 0.
REQ-024 SHALL make DIV of 0x80000000 by 0xFFFFFFFF give LO = 0x80000000 and HI = 0.
REQ-025 SHALL, on accept with MTHI/MTLO, write A into HI/LO on that same edge, with no BUSY state.
REQ-026 SHALL ignore start while busy is high; no capture occurs and no state changes.
REQ-027 SHALL suppress any start coinciding with Req, since that E-stage instruction is flushed.
REQ-028 SHALL let an operation already in BUSY when Req rises run to completion, because it belongs to an older committed instruction.
REQ-029 SHALL drive stall = busy | (start & (op is 1-4)).
REQ-030 SHALL ignore op 0 and op 7 even when start is high.

Reset
REQ-031 SHALL, on reset, set state IDLE, cnt 0, busy 0, HI 0, LO 0 and the latched operands to 0.
REQ-032 SHALL let reset abort an in-flight operation with no HI/LO write, and reset SHALL take priority over completion in the same cycle.

Structure
REQ-033 SHALL take op encodings 0-6 and state encodings from the shared `macro.v` defines, used by both the decoder and hilo_ctrl.
REQ-034 SHALL need no sub-module: the arithmetic stays inline, and results are computed from latched operands and committed at BUSY exit.

Verification
REQ-035 SHALL check: MULT A=0xFFFFFFFE, B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 SHALL check: DIVU A=100, B=7 -> busy high for 10 cycles, then LO=14, HI=2; then DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-037 SHALL check: MTLO A=0x1234 -> LO=0x1234 one edge later with busy never high; then DIV with B=0 -> HI/LO unchanged after 10 cycles.
REQ-038 SHALL check: start=1, op=MULT with Req=1 -> busy stays 0 and HI/LO are unchanged; Req raised during an active MULT -> result still committed at cycle 5.
REQ-039 SHALL check: MULTU start at busy cycle 2 of a DIV -> ignored and only the DIV result is written; reset at busy cycle 3 -> busy=0, HI=LO=0 next cycle and no later write.
REQ-040 SHALL check: stall is high in the accept cycle and for all busy cycles, and low on the first cycle after completion.

Source files
------------

// File: rtl/hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM state type and small decode helpers used by the decoder and hilo_ctrl.
package hilo_ctrl_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO register file with a multi-cycle multiply/divide unit. Operands are
// latched at issue and the result is committed on the edge that leaves BUSY.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HILO_out,
  output logic        state_o
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   a_q, b_q;
  logic [2:0]    op_q;

  logic          accept;
  logic [63:0]   prod_s, prod_u;
  logic          a_neg, b_neg;
  logic [31:0]   div_a, div_b;
  logic [31:0]   q_mag, r_mag;
  logic [31:0]   quot, rem;

  assign accept = start & ~Req & ~busy_q & ~reset;

  // Signed divide works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_neg  = (op_q == OP_DIV) & a_q[31];
    b_neg  = (op_q == OP_DIV) & b_q[31];
    div_a  = a_neg ? (~a_q + 32'd1) : a_q;
    div_b  = (b_q == 32'd0) ? 32'd1 : (b_neg ? (~b_q + 32'd1) : b_q);
    q_mag  = div_a / div_b;
    r_mag  = div_a % div_b;
    quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_muldiv(op)) begin
              a_q     <= A;
              b_q     <= B;
              op_q    <= op;
              cnt_q   <= is_div(op) ? DIV_LOAD : MULT_LOAD;
              busy_q  <= 1'b1;
              state_q <= ST_BUSY;
            end else if (op == OP_MTHI) begin
              hi_q <= A;
            end else if (op == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
            case (op_q)
              OP_MULT:  {hi_q, lo_q} <= prod_s;
              OP_MULTU: {hi_q, lo_q} <= prod_u;
              OP_DIV, OP_DIVU: begin
                // A zero divisor leaves HI/LO untouched.
                if (b_q != 32'd0) begin
                  lo_q <= quot;
                  hi_q <= rem;
                end
              end
              default: ;
            endcase
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign stall    = busy_q | (start & is_muldiv(op));
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign HILO_out = rd_sel ? hi_q : lo_q;
  assign state_o  = state_q;

endmodule
